// File: rtl/led_panel_renderer.sv
// VGA renderer for a row of indicator lights. It owns the sync timing and latches the LED and mode
// inputs once per frame, so a frame never shows two different LED patterns.
module led_panel_renderer #(
   parameter int unsigned N_LIGHTS    = 6,
   parameter int unsigned LIGHT_X0    = 224,
   parameter int unsigned LIGHT_PITCH = 80,
   parameter int unsigned LIGHT_W     = 40,
   parameter int unsigned LIGHT_Y0    = 229,
   parameter int unsigned LIGHT_H     = 31,
   parameter int unsigned H_VIS       = 640,
   parameter int unsigned H_FP        = 16,
   parameter int unsigned H_SYNC      = 96,
   parameter int unsigned H_BP        = 48,
   parameter int unsigned V_VIS       = 480,
   parameter int unsigned V_FP        = 10,
   parameter int unsigned V_SYNC      = 2,
   parameter int unsigned V_BP        = 33,
   parameter logic [23:0] BG_COLOR    = 24'h000080,
   parameter logic [23:0] ON_COLOR    = 24'hFF0000,
   parameter logic [23:0] OFF_COLOR   = 24'h404040,
   parameter int unsigned BLINK_LOG2  = 5
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                pix_en_i,
   input  logic [N_LIGHTS-1:0] leds_i,
   input  logic [1:0]          mode_i,
   output logic                hsync_o,
   output logic                vsync_o,
   output logic                bright_o,
   output logic [9:0]          hcount_o,
   output logic [9:0]          vcount_o,
   output logic [7:0]          vga_r_o,
   output logic [7:0]          vga_g_o,
   output logic [7:0]          vga_b_o
);

   localparam int unsigned HTot = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int unsigned VTot = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int unsigned FcW  = BLINK_LOG2 + 1;

   localparam logic [9:0] HMax       = 10'(HTot - 1);
   localparam logic [9:0] VMax       = 10'(VTot - 1);
   localparam logic [9:0] HVis       = 10'(H_VIS);
   localparam logic [9:0] VVis       = 10'(V_VIS);
   localparam logic [9:0] HSyncStart = 10'(H_VIS + H_FP);
   localparam logic [9:0] HSyncEnd   = 10'(H_VIS + H_FP + H_SYNC);
   localparam logic [9:0] VSyncStart = 10'(V_VIS + V_FP);
   localparam logic [9:0] VSyncEnd   = 10'(V_VIS + V_FP + V_SYNC);

   logic [9:0]          h_q, h_d, v_q, v_d;
   logic [N_LIGHTS-1:0] led_sh_q, led_sh_d;
   logic [1:0]          mode_sh_q, mode_sh_d;
   logic [FcW-1:0]      frame_q, frame_d;

   logic                hsync_q, vsync_q, bright_q;
   logic [9:0]          hcount_q, vcount_q;
   logic [23:0]         rgb_q;

   logic                hsync_c, vsync_c, bright_c;
   logic [23:0]         rgb_c;
   logic [N_LIGHTS-1:0] led_state;
   logic [N_LIGHTS-1:0] shifted;
   logic [31:0]         h_ext, v_ext;
   logic                in_row, any_hit, hit_on;

   always_comb begin
      h_d       = h_q;
      v_d       = v_q;
      led_sh_d  = led_sh_q;
      mode_sh_d = mode_sh_q;
      frame_d   = frame_q;
      if (pix_en_i) begin
         if (h_q == HMax) begin
            h_d = '0;
            v_d = (v_q == VMax) ? '0 : v_q + 10'd1;
         end else begin
            h_d = h_q + 10'd1;
         end
         // Start of frame: sample the live inputs so the whole frame uses one snapshot.
         if (h_q == '0 && v_q == '0) begin
            led_sh_d  = leds_i;
            mode_sh_d = mode_i;
            frame_d   = frame_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         h_q       <= '0;
         v_q       <= '0;
         led_sh_q  <= '0;
         mode_sh_q <= 2'b00;
         frame_q   <= '0;
      end else begin
         h_q       <= h_d;
         v_q       <= v_d;
         led_sh_q  <= led_sh_d;
         mode_sh_q <= mode_sh_d;
         frame_q   <= frame_d;
      end
   end

   always_comb begin
      unique case (mode_sh_q)
         2'b01:   led_state = led_sh_q & {N_LIGHTS{~frame_q[BLINK_LOG2]}};
         2'b10:   led_state = ~led_sh_q;
         default: led_state = led_sh_q;
      endcase
   end

   always_comb begin
      h_ext   = {22'd0, h_q};
      v_ext   = {22'd0, v_q};
      in_row  = (v_ext >= LIGHT_Y0) && (v_ext < LIGHT_Y0 + LIGHT_H);
      any_hit = 1'b0;
      hit_on  = 1'b0;
      shifted = '0;
      // Light 0 is leftmost and displays the most significant LED bit.
      for (int unsigned i = 0; i < N_LIGHTS; i++) begin
         if (h_ext >= LIGHT_X0 + i * LIGHT_PITCH &&
             h_ext < LIGHT_X0 + i * LIGHT_PITCH + LIGHT_W) begin
            shifted = led_state >> (N_LIGHTS - 1 - i);
            any_hit = 1'b1;
            hit_on  = shifted[0];
         end
      end
   end

   always_comb begin
      bright_c = (h_q < HVis) && (v_q < VVis);
      hsync_c  = !((h_q >= HSyncStart) && (h_q < HSyncEnd));
      vsync_c  = !((v_q >= VSyncStart) && (v_q < VSyncEnd));
      if (!bright_c) begin
         rgb_c = 24'h000000;
      end else if (any_hit && in_row) begin
         rgb_c = hit_on ? ON_COLOR : OFF_COLOR;
      end else begin
         rgb_c = BG_COLOR;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         hsync_q  <= 1'b1;
         vsync_q  <= 1'b1;
         bright_q <= 1'b0;
         hcount_q <= '0;
         vcount_q <= '0;
         rgb_q    <= '0;
      end else if (pix_en_i) begin
         hsync_q  <= hsync_c;
         vsync_q  <= vsync_c;
         bright_q <= bright_c;
         hcount_q <= h_q;
         vcount_q <= v_q;
         rgb_q    <= rgb_c;
      end
   end

   assign hsync_o  = hsync_q;
   assign vsync_o  = vsync_q;
   assign bright_o = bright_q;
   assign hcount_o = hcount_q;
   assign vcount_o = vcount_q;
   assign vga_r_o  = rgb_q[23:16];
   assign vga_g_o  = rgb_q[15:8];
   assign vga_b_o  = rgb_q[7:0];

endmodule

// File: tb/tb_led_panel_renderer.sv
// Bench for led_panel_renderer on a shrunken raster: a frame-position model predicts every output,
// with literal spot checks for colours, syncs, frame latching, blink phase and async reset.
module tb_led_panel_renderer;

   localparam int NL = 6, X0 = 4, PITCH = 6, LW = 3, Y0 = 5, LH = 4;
   localparam int HV = 40, HF = 4, HS = 6, HB = 6;
   localparam int VV = 20, VF = 2, VS = 2, VB = 3;
   localparam int BL = 1;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int FR = HT * VT;
   localparam logic [23:0] BG = 24'h000080, ON = 24'hFF0000, OFF = 24'h404040;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          pix_en = 1'b0;
   logic [NL-1:0] leds = '0;
   logic [1:0]    mode = 2'b00;
   logic          hsync, vsync, bright;
   logic [9:0]    hcount, vcount;
   logic [7:0]    vga_r, vga_g, vga_b;
   logic [23:0]   rgb;

   int checks = 0;
   int failures = 0;
   logic chk_en = 1'b0;
   logic lit_phase = 1'b0, lit2_phase = 1'b0, blink_phase = 1'b0;
   int blink_idx = 0;
   logic exp_blink [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

   always #5 clk = ~clk;

   led_panel_renderer #(
      .N_LIGHTS(NL), .LIGHT_X0(X0), .LIGHT_PITCH(PITCH), .LIGHT_W(LW), .LIGHT_Y0(Y0),
      .LIGHT_H(LH), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_VIS(VV), .V_FP(VF),
      .V_SYNC(VS), .V_BP(VB), .BG_COLOR(BG), .ON_COLOR(ON), .OFF_COLOR(OFF), .BLINK_LOG2(BL)
   ) dut (
      .clk_i(clk), .reset_i(reset), .pix_en_i(pix_en), .leds_i(leds), .mode_i(mode),
      .hsync_o(hsync), .vsync_o(vsync), .bright_o(bright), .hcount_o(hcount),
      .vcount_o(vcount), .vga_r_o(vga_r), .vga_g_o(vga_g), .vga_b_o(vga_b)
   );

   assign rgb = {vga_r, vga_g, vga_b};

   // Reference model: a linear pixel position within the frame plus a per-frame snapshot.
   int          pos;
   logic [NL-1:0] m_shadow;
   logic [1:0]  m_mode;
   int          m_fcnt;
   logic        exp_hs, exp_vs, exp_br;
   logic [9:0]  exp_h, exp_v;
   logic [23:0] exp_rgb;

   function automatic logic [23:0] model_rgb(int h, int v, logic [NL-1:0] sh, logic [1:0] md,
                                             int fc);
      int  idx;
      logic s;
      if (!(h < HV && v < VV)) return 24'h0;
      if (v < Y0 || v >= Y0 + LH || h < X0) return BG;
      idx = (h - X0) / PITCH;
      if (idx >= NL || (h - X0) % PITCH >= LW) return BG;
      s = sh[NL - 1 - idx];
      if (md == 2'b01) s = s && (((fc >> BL) % 2) == 0);
      else if (md == 2'b10) s = !s;
      return s ? ON : OFF;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         pos <= 0; m_shadow <= '0; m_mode <= 2'b00; m_fcnt <= 0;
         exp_hs <= 1'b1; exp_vs <= 1'b1; exp_br <= 1'b0;
         exp_h <= '0; exp_v <= '0; exp_rgb <= '0;
      end else if (pix_en) begin
         exp_h   <= 10'(pos % HT);
         exp_v   <= 10'(pos / HT);
         exp_hs  <= !((pos % HT) >= HV + HF && (pos % HT) < HV + HF + HS);
         exp_vs  <= !((pos / HT) >= VV + VF && (pos / HT) < VV + VF + VS);
         exp_br  <= (pos % HT) < HV && (pos / HT) < VV;
         exp_rgb <= model_rgb(pos % HT, pos / HT, m_shadow, m_mode, m_fcnt);
         if (pos == 0) begin
            m_shadow <= leds;
            m_mode   <= mode;
            m_fcnt   <= (m_fcnt + 1) % (1 << (BL + 1));
         end
         pos <= (pos + 1) % FR;
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at h=%0d v=%0d t=%0t", nm, act, exp,
                  hcount, vcount, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("hsync", 32'(hsync), 32'(exp_hs));
         check("vsync", 32'(vsync), 32'(exp_vs));
         check("bright", 32'(bright), 32'(exp_br));
         check("hcount", 32'(hcount), 32'(exp_h));
         check("vcount", 32'(vcount), 32'(exp_v));
         check("rgb", 32'(rgb), 32'(exp_rgb));
      end
      if (lit_phase) begin
         if (vcount == 6 && hcount == 2)  check("lit_bg", 32'(rgb), 32'(BG));
         if (vcount == 6 && hcount == 5)  check("lit_off", 32'(rgb), 32'(OFF));
         if (vcount == 6 && hcount == 11) check("lit_on1", 32'(rgb), 32'(ON));
         if (vcount == 6 && hcount == 17) check("lit_on2", 32'(rgb), 32'(ON));
         if (vcount == 6 && hcount == 45) check("lit_blank", 32'(rgb), 32'h0);
         if (vcount == 6 && hcount == 44) check("lit_hs_lo", 32'(hsync), 32'h0);
         if (vcount == 6 && hcount == 43) check("lit_hs_hi", 32'(hsync), 32'h1);
         if (vcount == 0 && hcount == 39) check("lit_br_hi", 32'(bright), 32'h1);
         if (vcount == 0 && hcount == 40) check("lit_br_lo", 32'(bright), 32'h0);
         if (vcount == 22 && hcount == 0) check("lit_vs_lo", 32'(vsync), 32'h0);
         if (vcount == 21 && hcount == 0) check("lit_vs_hi", 32'(vsync), 32'h1);
      end
      if (lit2_phase) begin
         if (vcount == 6 && hcount == 11) check("lit2_off", 32'(rgb), 32'(OFF));
         if (vcount == 6 && hcount == 35) check("lit2_on", 32'(rgb), 32'(ON));
      end
      if (!blink_phase) begin
         blink_idx = 0;
      end else if (vcount == 6 && hcount == 35 && blink_idx < 5) begin
         check("blink", 32'(rgb), 32'(exp_blink[blink_idx] ? ON : OFF));
         blink_idx++;
      end
   end

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string nm);
      check({nm, "_hs"}, 32'(hsync), 32'h1);
      check({nm, "_vs"}, 32'(vsync), 32'h1);
      check({nm, "_br"}, 32'(bright), 32'h0);
      check({nm, "_h"}, 32'(hcount), 32'h0);
      check({nm, "_v"}, 32'(vcount), 32'h0);
      check({nm, "_rgb"}, 32'(rgb), 32'h0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 reset = 1'b1;
      run(2);
      reset = 1'b0;
   endtask

   initial begin
      bit found;
      #1 reset = 1'b1;
      #2 check_reset_outputs("rst0");
      chk_en = 1'b1;
      run(3);
      // Frame 0 shows 011000; the mid-frame change must wait for frame 1.
      reset = 1'b0; leds = 6'b011000; mode = 2'b00; pix_en = 1'b1; lit_phase = 1'b1;
      run(FR + HT * 3);
      leds = 6'b000001;
      run(HT * 6);
      lit_phase = 1'b0; lit2_phase = 1'b1;
      run(FR);
      lit2_phase = 1'b0;

      do_reset();
      leds = 6'b111111; mode = 2'b01; blink_phase = 1'b1;
      run(5 * FR);
      blink_phase = 1'b0;

      leds = 6'b011000; mode = 2'b10;
      run(2 * FR);
      mode = 2'b11;
      run(2 * FR);

      repeat (8000) begin
         @(negedge clk);
         pix_en = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 199) == 0) begin
            leds = NL'($urandom);
            mode = 2'($urandom);
         end
      end

      found = 1'b0;
      for (int i = 0; i < 4 * HT && !found; i++) begin
         @(negedge clk);
         if (hcount == 20) found = 1'b1;
         else pix_en = ~pix_en;
      end
      if (!found) begin
         checks++; failures++;
         $display("FAIL wait_hcount20 actual=timeout required=hcount 20");
      end
      #2 reset = 1'b1;
      #1 check_reset_outputs("rst_async");
      run(3);
      reset = 1'b0; pix_en = 1'b1;
      run(200);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
